// File: rtl/key_pkg.sv
// Shared constants and FSM state encoding for the key scan/debounce filter.
// Long-press defaults exist only when KEY_LONG_PRESS_EN is defined.
package key_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_DOWN_FILT = 2'd1,
      ST_PRESSED   = 2'd2,
      ST_UP_FILT   = 2'd3
   } key_state_e;

   localparam int unsigned CNT_MAX_DEF = 1000000;
   localparam int unsigned CNT_W_DEF   = 20;

`ifdef KEY_LONG_PRESS_EN
   localparam int unsigned LONG_MAX_DEF = 50000000;
   localparam int unsigned LONG_W_DEF   = 26;
`endif

endpackage

// File: rtl/key_scan_filter_if.sv
// Key bank signal bundle: raw active-low pins in, debounced level and pulses out.
// key_long is present only when KEY_LONG_PRESS_EN is defined.
interface key_scan_filter_if #(
   parameter int unsigned NUM_KEYS = 4
);
   logic [NUM_KEYS-1:0] key_n;
   logic [NUM_KEYS-1:0] key_pressed;
   logic [NUM_KEYS-1:0] key_press;
   logic [NUM_KEYS-1:0] key_release;
`ifdef KEY_LONG_PRESS_EN
   logic [NUM_KEYS-1:0] key_long;
`endif

   modport master (
      output key_n,
      input  key_pressed,
      input  key_press,
      input  key_release
`ifdef KEY_LONG_PRESS_EN
      , input key_long
`endif
   );

   modport slave (
      input  key_n,
      output key_pressed,
      output key_press,
      output key_release
`ifdef KEY_LONG_PRESS_EN
      , output key_long
`endif
   );
endinterface

// File: rtl/key_filter_ch.sv
// One debounce channel: 2-flop synchroniser, edge detect, filter FSM with counter.
// KEY_LONG_PRESS_EN adds a one-shot long-press pulse while held.
module key_filter_ch
   import key_pkg::*;
#(
   parameter int unsigned CNT_MAX  = CNT_MAX_DEF,
   parameter int unsigned CNT_W    = CNT_W_DEF
`ifdef KEY_LONG_PRESS_EN
   , parameter int unsigned LONG_MAX = LONG_MAX_DEF
   , parameter int unsigned LONG_W   = LONG_W_DEF
`endif
) (
   input  logic clk,
   input  logic rst,
   input  logic key_n,
   output logic key_pressed,
   output logic key_press,
   output logic key_release
`ifdef KEY_LONG_PRESS_EN
   , output logic key_long
`endif
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

   logic [1:0]  sync_q;
   logic        k_prev_q;
   logic [2:0]  vld_q;
   logic [CNT_W-1:0] cnt_q;
   key_state_e  state_q;
   logic        k_s, fall, rise;

   // vld_q[2] marks k_prev_q as a real pin sample, so a key held through reset
   // does not look like a falling edge against the all-ones reset values.
   assign k_s  = sync_q[1];
   assign fall = vld_q[2] & k_prev_q & ~k_s;
   assign rise = k_s & ~k_prev_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q      <= 2'b11;
         k_prev_q    <= 1'b1;
         vld_q       <= '0;
         cnt_q       <= '0;
         state_q     <= ST_IDLE;
         key_pressed <= 1'b0;
         key_press   <= 1'b0;
         key_release <= 1'b0;
      end else begin
         sync_q      <= {sync_q[0], key_n};
         k_prev_q    <= k_s;
         vld_q       <= {vld_q[1:0], 1'b1};
         key_press   <= 1'b0;
         key_release <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (fall) begin
                  state_q <= ST_DOWN_FILT;
                  cnt_q   <= '0;
               end
            end
            ST_DOWN_FILT: begin
               if (k_s) begin
                  state_q <= ST_IDLE;
               end else if (cnt_q == CNT_LAST) begin
                  state_q     <= ST_PRESSED;
                  key_press   <= 1'b1;
                  key_pressed <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_PRESSED: begin
               if (rise) begin
                  state_q <= ST_UP_FILT;
                  cnt_q   <= '0;
               end
            end
            ST_UP_FILT: begin
               if (!k_s) begin
                  state_q <= ST_PRESSED;
               end else if (cnt_q == CNT_LAST) begin
                  state_q     <= ST_IDLE;
                  key_release <= 1'b1;
                  key_pressed <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

`ifdef KEY_LONG_PRESS_EN
   localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_MAX - 1);

   logic [LONG_W-1:0] long_cnt_q;

   // Counter parks one past LONG_LAST so the pulse fires only once per hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         long_cnt_q <= '0;
         key_long   <= 1'b0;
      end else begin
         key_long <= 1'b0;
         if (state_q != ST_PRESSED || rise) begin
            long_cnt_q <= '0;
         end else if (long_cnt_q < LONG_LAST) begin
            long_cnt_q <= long_cnt_q + LONG_W'(1);
         end else if (long_cnt_q == LONG_LAST) begin
            long_cnt_q <= long_cnt_q + LONG_W'(1);
            key_long   <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/key_scan_filter.sv
// Key bank debounce filter: NUM_KEYS independent key_filter_ch channels.
// Define KEY_LONG_PRESS_EN to add the key_long one-shot output.
module key_scan_filter
   import key_pkg::*;
#(
   parameter int unsigned NUM_KEYS = 4,
   parameter int unsigned CNT_MAX  = CNT_MAX_DEF,
   parameter int unsigned CNT_W    = CNT_W_DEF
`ifdef KEY_LONG_PRESS_EN
   , parameter int unsigned LONG_MAX = LONG_MAX_DEF
   , parameter int unsigned LONG_W   = LONG_W_DEF
`endif
) (
   input logic              clk,
   input logic              rst,
   key_scan_filter_if.slave bus
);

   logic [NUM_KEYS-1:0] pressed_v, press_v, release_v;
`ifdef KEY_LONG_PRESS_EN
   logic [NUM_KEYS-1:0] long_v;
`endif

   for (genvar i = 0; i < int'(NUM_KEYS); i++) begin : g_ch
      key_filter_ch #(
         .CNT_MAX  (CNT_MAX),
         .CNT_W    (CNT_W)
`ifdef KEY_LONG_PRESS_EN
         , .LONG_MAX (LONG_MAX)
         , .LONG_W   (LONG_W)
`endif
      ) u_ch (
         .clk         (clk),
         .rst         (rst),
         .key_n       (bus.key_n[i]),
         .key_pressed (pressed_v[i]),
         .key_press   (press_v[i]),
         .key_release (release_v[i])
`ifdef KEY_LONG_PRESS_EN
         , .key_long  (long_v[i])
`endif
      );
   end

   assign bus.key_pressed = pressed_v;
   assign bus.key_press   = press_v;
   assign bus.key_release = release_v;
`ifdef KEY_LONG_PRESS_EN
   assign bus.key_long    = long_v;
`endif

endmodule

// File: tb/tb_key_scan_filter.sv
// Directed bench for key_scan_filter with CNT_MAX=10 (and LONG_MAX=40 when
// KEY_LONG_PRESS_EN is defined).
module tb_key_scan_filter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #10 clk = ~clk;

   key_scan_filter_if #(.NUM_KEYS(4)) bus ();

   key_scan_filter #(
      .NUM_KEYS (4),
      .CNT_MAX  (10),
      .CNT_W    (8)
`ifdef KEY_LONG_PRESS_EN
      , .LONG_MAX (40)
      , .LONG_W   (8)
`endif
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [3:0] key_n;
      int         cycles;
      logic [3:0] pressed;
      logic [3:0] press;
      logic [3:0] rel;
   } vec_t;

   int vectors = 0;
   int errors  = 0;
   int press_cnt [4] = '{default: 0};
   int rel_cnt   [4] = '{default: 0};
   int long_cnt  [4] = '{default: 0};
   int overlap_cnt = 0;

   // Pulse counters sampled on the falling edge, away from output updates.
   always @(negedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 4; i++) begin
            if (bus.key_press[i])   press_cnt[i] <= press_cnt[i] + 1;
            if (bus.key_release[i]) rel_cnt[i]   <= rel_cnt[i] + 1;
`ifdef KEY_LONG_PRESS_EN
            if (bus.key_long[i])    long_cnt[i]  <= long_cnt[i] + 1;
`endif
         end
         if ((bus.key_press & bus.key_release) != 4'h0) overlap_cnt <= overlap_cnt + 1;
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   vec_t tbl [14];
   int   snap;

   initial begin
      // Clean press on key 0 (T = first drive of E), then all four at once.
      tbl[0]  = '{4'hF,  1, 4'h0, 4'h0, 4'h0};
      tbl[1]  = '{4'hE, 12, 4'h0, 4'h0, 4'h0};
      tbl[2]  = '{4'hE,  1, 4'h1, 4'h1, 4'h0};
      tbl[3]  = '{4'hE,  1, 4'h1, 4'h0, 4'h0};
      tbl[4]  = '{4'hE, 36, 4'h1, 4'h0, 4'h0};
      tbl[5]  = '{4'hF, 12, 4'h1, 4'h0, 4'h0};
      tbl[6]  = '{4'hF,  1, 4'h0, 4'h0, 4'h1};
      tbl[7]  = '{4'hF,  1, 4'h0, 4'h0, 4'h0};
      tbl[8]  = '{4'hF, 20, 4'h0, 4'h0, 4'h0};
      tbl[9]  = '{4'h0, 12, 4'h0, 4'h0, 4'h0};
      tbl[10] = '{4'h0,  1, 4'hF, 4'hF, 4'h0};
      tbl[11] = '{4'h0,  1, 4'hF, 4'h0, 4'h0};
      tbl[12] = '{4'hF, 13, 4'h0, 4'h0, 4'hF};
      tbl[13] = '{4'hF,  1, 4'h0, 4'h0, 4'h0};

      rst = 1'b1;
      bus.key_n = 4'hF;
      step(10);
      check("reset_pressed", 16'(bus.key_pressed), 16'h0);
      check("reset_press",   16'(bus.key_press),   16'h0);
      check("reset_release", 16'(bus.key_release), 16'h0);
`ifdef KEY_LONG_PRESS_EN
      check("reset_long",    16'(bus.key_long),    16'h0);
`endif
      rst = 1'b0;
      step(100);
      check("idle_no_press",   16'(press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3]), 16'h0);
      check("idle_no_release", 16'(rel_cnt[0] + rel_cnt[1] + rel_cnt[2] + rel_cnt[3]), 16'h0);

      for (int i = 0; i < 14; i++) begin
         bus.key_n = tbl[i].key_n;
         step(tbl[i].cycles);
         check($sformatf("tbl%0d {pressed,press,release}", i),
               16'({bus.key_pressed, bus.key_press, bus.key_release}),
               16'({tbl[i].pressed, tbl[i].press, tbl[i].rel}));
      end

      // Bounce on key 1: low 5, high 3, low 4, then high.
      snap = press_cnt[1];
      bus.key_n = 4'hD; step(5);
      bus.key_n = 4'hF; step(3);
      bus.key_n = 4'hD; step(4);
      bus.key_n = 4'hF; step(20);
      check("bounce_no_press", 16'(press_cnt[1] - snap), 16'h0);
      check("bounce_pressed",  16'(bus.key_pressed), 16'h0);
      bus.key_n = 4'hD; step(20);
      check("bounce_hold_one_press", 16'(press_cnt[1] - snap), 16'h1);
      check("bounce_hold_pressed",   16'(bus.key_pressed), 16'h2);
      bus.key_n = 4'hF; step(20);
      check("bounce_released", 16'(bus.key_pressed), 16'h0);

      // Reset during DOWN_FILT on key 2 (counter at 5), key held through reset.
      snap = press_cnt[2];
      bus.key_n = 4'hB; step(8);
      rst = 1'b1; step(3);
      check("rstmid_pressed", 16'(bus.key_pressed), 16'h0);
      rst = 1'b0; step(40);
      check("rstmid_no_press",   16'(press_cnt[2] - snap), 16'h0);
      check("rstmid_held_level", 16'(bus.key_pressed), 16'h0);
      bus.key_n = 4'hF; step(5);
      bus.key_n = 4'hB; step(12);
      check("repress_early", 16'(bus.key_press), 16'h0);
      step(1);
      check("repress_pulse",   16'(bus.key_press),   16'h4);
      check("repress_pressed", 16'(bus.key_pressed), 16'h4);
      bus.key_n = 4'hF; step(20);

`ifdef KEY_LONG_PRESS_EN
      bus.key_n = 4'h7; step(13);
      check("long_press_pulse", 16'(bus.key_press), 16'h8);
      snap = long_cnt[3];
      step(39);
      check("long_early", 16'(bus.key_long), 16'h0);
      step(1);
      check("long_pulse", 16'(bus.key_long), 16'h8);
      step(1);
      check("long_one_cycle", 16'(bus.key_long), 16'h0);
      step(59);
      check("long_single", 16'(long_cnt[3] - snap), 16'h1);
      check("long_still_pressed", 16'(bus.key_pressed), 16'h8);
      bus.key_n = 4'hF; step(13);
      check("long_release", 16'(bus.key_release), 16'h8);
      check("long_released_level", 16'(bus.key_pressed), 16'h0);
`endif

      step(2);
      check("press_release_overlap", 16'(overlap_cnt), 16'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/key_scan_filter.md
Name: key_scan_filter

Overview:
- Input-side companion to the LED output drivers: samples 4 active-low push-buttons and synchronises them into clk.
- Debounces each button independently.
- Emits a stable pressed level plus single-cycle press and release pulses for downstream LED/control logic.
- 50 MHz system clock (20 ns period); one instance per board key bank.

Parameters:
- NUM_KEYS, 4, number of independent key channels.
- CNT_MAX, 1000000, debounce window in clk cycles (20 ms at 50 MHz); the bench uses 10.
- CNT_W, 20, counter width; must satisfy 2^CNT_W > CNT_MAX.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst  input  1  synchronous, active-high reset.
- key_n  input  NUM_KEYS  raw asynchronous button pins, active-low (0 = pressed).
- key_pressed  output  NUM_KEYS  debounced level, active-high (1 = held).
- key_press  output  NUM_KEYS  1-cycle pulse on confirmed press.
- key_release  output  NUM_KEYS  1-cycle pulse on confirmed release.

Behaviour:
- Reset is synchronous and active-high. Clock and reset ports are clk and rst. Sampled on the clk rising edge only.
- Reset values:
  - key_pressed = 0, key_press = 0, key_release = 0.
  - Synchroniser flops = all-ones (released).
  - Counters = 0; every channel FSM = IDLE.
- Synchroniser: 2-flop chain per key, giving k_s. The FSM sees a key_n change 2 cycles later. A third flop holds k_s from the previous cycle for edge detection.
- Per-channel FSM, 2-bit state:
  - IDLE: wait for falling edge on k_s, then go to DOWN_FILT and clear the counter.
  - DOWN_FILT:
    - k_s==0: count up.
    - k_s returns to 1 before the counter reaches CNT_MAX-1: go to IDLE (glitch rejected, no pulse).
    - Counter reaches CNT_MAX-1 with k_s==0: go to PRESSED. Same cycle registers key_press=1 and key_pressed=1.
  - PRESSED: wait for rising edge on k_s, then go to UP_FILT and clear the counter.
  - UP_FILT:
    - Symmetric to DOWN_FILT.
    - Bounce back to 0 returns to PRESSED; key_pressed stays 1.
    - Confirm registers key_release=1 and key_pressed=0, then go to IDLE.
- Latency: press pulse asserted exactly 2 (sync) + 1 (edge) + CNT_MAX cycles after a clean key_n falling edge.
- key_press and key_release are registered and high for exactly one cycle. They are never both high on the same channel in the same cycle.
- Channels are fully independent. Simultaneous presses on several keys produce pulses in the same cycle.
- Counter saturates conceptually: it is cleared on every state entry and never wraps.
- Reset mid-filter or mid-press returns the channel to IDLE with no pulse. A key held through reset release needs a fresh falling edge before a press is reported.

Optional Feature:
- Macro: KEY_LONG_PRESS_EN.
- When defined:
  - Adds parameter LONG_MAX, default 50000000 (1 s); the bench uses 40.
  - Adds output key_long[NUM_KEYS], a 1-cycle pulse.
  - In PRESSED, a second counter increments each cycle. At LONG_MAX-1 it pulses key_long once and then holds; there is no repeat.
  - Leaving PRESSED clears that counter.
  - key_long resets to 0.
- When undefined: the port, parameter and counter are absent. Behaviour is otherwise identical.

Decomposition:
- Package key_pkg:
  - State localparams ST_IDLE=2'd0, ST_DOWN_FILT=2'd1, ST_PRESSED=2'd2, ST_UP_FILT=2'd3.
  - Default CNT_MAX and LONG_MAX constants.
- Sub-module key_filter_ch: one channel (sync, edge detect, FSM, counter).
- The top generates NUM_KEYS instances and concatenates the outputs.

Test Plan:
- Reset: rst=1 for 10 cycles with key_n=4'hF → all outputs 0. Release rst, idle 100 cycles → no pulses.
- Clean press, CNT_MAX=10: key_n[0] 1→0 at cycle T.
  - key_press[0] high only at T+13.
  - key_pressed[0]=1 from T+13.
  - Release at T+50 → key_release[0] pulse at T+63, key_pressed[0]=0.
- Bounce rejection: key_n[1] low 5 cycles, high 3, low 4, then high → no key_press[1] ever.
  - Then hold low 20 cycles → exactly one pulse.
- Simultaneous: key_n 4'hF→4'h0 in one cycle → key_press=4'hF in one cycle 13 cycles later; key_pressed=4'hF.
- Reset mid-operation: press key 2, assert rst at DOWN_FILT count 5 → no pulse.
  - Keep key held while rst deasserts → no pulse until release and re-press.
- With KEY_LONG_PRESS_EN, LONG_MAX=40: hold key 3 for 100 cycles after press confirm.
  - key_long[3] single pulse 40 cycles after key_press[3]; none afterwards.
  - Release → key_release[3] as normal.
